// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared types for the fetch/load-store memory arbiter
package riscv_mem_pkg;

  localparam int REQ_XLEN   = 32;
  localparam int REQ_STRB_W = REQ_XLEN / 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  typedef enum logic {
    OWNER_INSN,
    OWNER_DATA
  } owner_e;

  typedef struct packed {
    logic [REQ_XLEN-1:0]   addr;
    logic                  write;
    logic [REQ_STRB_W-1:0] wstrb;
    logic [REQ_XLEN-1:0]   wdata;
  } mem_req_t;

endpackage

// File: rtl/riscv_arb_priority.sv
// rtl/riscv_arb_priority.sv - data-over-fetch grant select with saturating starvation counter
module riscv_arb_priority
  import riscv_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic arb_en_i,
  input  logic insn_valid_i,
  input  logic data_valid_i,
  output logic grant_insn_o,
  output logic grant_data_o
);

  // A limit of 0 still needs a 1-bit counter; it simply never leaves 0.
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;

  always_comb begin
    grant_insn_o = arb_en_i && insn_valid_i && (!data_valid_i || starve_cnt_q == LIMIT);
    grant_data_o = arb_en_i && data_valid_i && !grant_insn_o;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_insn_o) begin
      starve_cnt_d = '0;
    end else if (grant_data_o && insn_valid_i && starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - shares one memory port between fetch and load/store requesters
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              insn_req_valid,
  output logic              insn_req_ready,
  input  logic [XLEN-1:0]   insn_addr,
  output logic              insn_resp_valid,
  output logic [XLEN-1:0]   insn_resp_data,
  input  logic              data_req_valid,
  output logic              data_req_ready,
  input  logic [XLEN-1:0]   data_addr,
  input  logic              data_write,
  input  logic [XLEN/8-1:0] data_wstrb,
  input  logic [XLEN-1:0]   data_wdata,
  output logic              data_resp_valid,
  output logic [XLEN-1:0]   data_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_write,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_data
);

  state_e            state_q;
  owner_e            owner_q;
  logic              grant_insn;
  logic              grant_data;
  logic              mem_req_valid_q;
  logic [XLEN-1:0]   mem_addr_q;
  logic              mem_write_q;
  logic [XLEN/8-1:0] mem_wstrb_q;
  logic [XLEN-1:0]   mem_wdata_q;
  logic              insn_resp_valid_q;
  logic [XLEN-1:0]   insn_resp_data_q;
  logic              data_resp_valid_q;
  logic [XLEN-1:0]   data_resp_data_q;

  riscv_arb_priority #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_priority (
    .clock       (clock),
    .reset       (reset),
    .arb_en_i    (state_q == IDLE),
    .insn_valid_i(insn_req_valid),
    .data_valid_i(data_req_valid),
    .grant_insn_o(grant_insn),
    .grant_data_o(grant_data)
  );

  assign insn_req_ready  = grant_insn;
  assign data_req_ready  = grant_data;
  assign mem_req_valid   = mem_req_valid_q;
  assign mem_addr        = mem_addr_q;
  assign mem_write       = mem_write_q;
  assign mem_wstrb       = mem_wstrb_q;
  assign mem_wdata       = mem_wdata_q;
  assign insn_resp_valid = insn_resp_valid_q;
  assign insn_resp_data  = insn_resp_data_q;
  assign data_resp_valid = data_resp_valid_q;
  assign data_resp_data  = data_resp_data_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q           <= IDLE;
      owner_q           <= OWNER_INSN;
      mem_req_valid_q   <= 1'b0;
      mem_addr_q        <= '0;
      mem_write_q       <= 1'b0;
      mem_wstrb_q       <= '0;
      mem_wdata_q       <= '0;
      insn_resp_valid_q <= 1'b0;
      insn_resp_data_q  <= '0;
      data_resp_valid_q <= 1'b0;
      data_resp_data_q  <= '0;
    end else begin
      insn_resp_valid_q <= 1'b0;
      data_resp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_insn) begin
            mem_addr_q      <= insn_addr;
            mem_write_q     <= 1'b0;
            mem_wstrb_q     <= '0;
            mem_wdata_q     <= '0;
            owner_q         <= OWNER_INSN;
            mem_req_valid_q <= 1'b1;
            state_q         <= ISSUE;
          end else if (grant_data) begin
            mem_addr_q      <= data_addr;
            mem_write_q     <= data_write;
            mem_wstrb_q     <= data_wstrb;
            mem_wdata_q     <= data_wdata;
            owner_q         <= OWNER_DATA;
            mem_req_valid_q <= 1'b1;
            state_q         <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= WAIT;
          end
        end
        WAIT: begin
          // Responses outside WAIT are protocol violations and never reach this branch.
          if (mem_resp_valid) begin
            if (owner_q == OWNER_INSN) begin
              insn_resp_valid_q <= 1'b1;
              insn_resp_data_q  <= mem_resp_data;
            end else begin
              data_resp_valid_q <= 1'b1;
              data_resp_data_q  <= mem_write_q ? '0 : mem_resp_data;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - directed self-checking bench for riscv_mem_arbiter
module tb_riscv_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        insn_req_valid;
  logic        insn_req_ready;
  logic [31:0] insn_addr;
  logic        insn_resp_valid;
  logic [31:0] insn_resp_data;
  logic        data_req_valid;
  logic        data_req_ready;
  logic [31:0] data_addr;
  logic        data_write;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_resp_valid;
  logic [31:0] data_resp_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  int errors = 0;
  int checks = 0;

  riscv_mem_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .insn_req_valid (insn_req_valid),
    .insn_req_ready (insn_req_ready),
    .insn_addr      (insn_addr),
    .insn_resp_valid(insn_resp_valid),
    .insn_resp_data (insn_resp_data),
    .data_req_valid (data_req_valid),
    .data_req_ready (data_req_ready),
    .data_addr      (data_addr),
    .data_write     (data_write),
    .data_wstrb     (data_wstrb),
    .data_wdata     (data_wdata),
    .data_resp_valid(data_resp_valid),
    .data_resp_data (data_resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_write      (mem_write),
    .mem_wstrb      (mem_wstrb),
    .mem_wdata      (mem_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Handshake on the next edge, respond one cycle later; returns with the pulse visible.
  task automatic serve(input logic [31:0] rdata);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = rdata;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
  endtask

  string exp_seq = "DDDDIDDDDI";
  logic [7:0] got_grant;
  logic       was_insn;

  initial begin
    reset = 1'b0;
    insn_req_valid = 0; insn_addr = 0;
    data_req_valid = 0; data_addr = 0; data_write = 0; data_wstrb = 0; data_wdata = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    check("rst_mem_req_valid", {31'b0, mem_req_valid}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_insn_resp_valid", {31'b0, insn_resp_valid}, 0);
    check("rst_data_resp_valid", {31'b0, data_resp_valid}, 0);
    check("rst_insn_resp_data", insn_resp_data, 0);
    check("rst_data_resp_data", data_resp_data, 0);
    check("rst_readies", {30'b0, insn_req_ready, data_req_ready}, 0);

    // Single fetch
    insn_req_valid = 1; insn_addr = 32'h100;
    #1;
    check("fetch_ready", {30'b0, insn_req_ready, data_req_ready}, 32'h2);
    tick();
    insn_req_valid = 0;
    check("fetch_mem_valid", {31'b0, mem_req_valid}, 1);
    check("fetch_mem_addr", mem_addr, 32'h100);
    check("fetch_mem_write", {31'b0, mem_write}, 0);
    serve(32'hDEADBEEF);
    check("fetch_resp_valid", {31'b0, insn_resp_valid}, 1);
    check("fetch_resp_data", insn_resp_data, 32'hDEADBEEF);
    check("fetch_no_data_resp", {31'b0, data_resp_valid}, 0);
    tick();
    check("fetch_pulse_once", {31'b0, insn_resp_valid}, 0);
    check("fetch_data_hold", insn_resp_data, 32'hDEADBEEF);

    // Store
    data_req_valid = 1; data_addr = 32'h200; data_write = 1; data_wstrb = 4'b0011; data_wdata = 32'h1234;
    #1;
    check("store_ready", {30'b0, insn_req_ready, data_req_ready}, 32'h1);
    tick();
    data_req_valid = 0; data_write = 0; data_wstrb = 0; data_wdata = 0;
    check("store_mem_addr", mem_addr, 32'h200);
    check("store_mem_write", {31'b0, mem_write}, 1);
    check("store_mem_wstrb", {28'b0, mem_wstrb}, 32'h3);
    check("store_mem_wdata", mem_wdata, 32'h1234);
    serve(32'hFFFFFFFF);
    check("store_resp_valid", {31'b0, data_resp_valid}, 1);
    check("store_resp_data", data_resp_data, 0);
    check("store_no_insn_resp", {31'b0, insn_resp_valid}, 0);

    // Contention: both valids held high
    insn_req_valid = 1; insn_addr = 32'h300;
    data_req_valid = 1; data_addr = 32'h400;
    #1;
    for (int i = 0; i < 10; i++) begin
      got_grant = insn_req_ready ? "I" : (data_req_ready ? "D" : "-");
      check($sformatf("contention_grant%0d", i), {24'b0, got_grant}, {24'b0, exp_seq[i]});
      was_insn = insn_req_ready;
      tick();
      check($sformatf("contention_addr%0d", i), mem_addr, was_insn ? 32'h300 : 32'h400);
      serve(32'hA0 + i);
      check($sformatf("contention_resp%0d", i), {31'b0, (was_insn ? insn_resp_valid : data_resp_valid)}, 1);
    end
    insn_req_valid = 0; data_req_valid = 0;

    // Backpressure
    tick();
    data_req_valid = 1; data_addr = 32'h500;
    tick();
    data_req_valid = 1; insn_req_valid = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_mem_valid", {31'b0, mem_req_valid}, 1);
      check("bp_mem_addr", mem_addr, 32'h500);
      check("bp_readies", {30'b0, insn_req_ready, data_req_ready}, 0);
      tick();
    end
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    check("bp_wait_readies", {30'b0, insn_req_ready, data_req_ready}, 0);
    insn_req_valid = 0; data_req_valid = 0;
    mem_resp_valid = 1; mem_resp_data = 32'hCAFE0001;
    tick();
    mem_resp_valid = 0;
    check("bp_resp_valid", {31'b0, data_resp_valid}, 1);
    check("bp_resp_data", data_resp_data, 32'hCAFE0001);

    // Reset while in WAIT
    insn_req_valid = 1; insn_addr = 32'h600;
    tick();
    insn_req_valid = 0;
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    reset = 0;
    tick();
    reset = 1;
    check("rstw_mem_valid", {31'b0, mem_req_valid}, 0);
    check("rstw_mem_addr", mem_addr, 0);
    check("rstw_insn_data", insn_resp_data, 0);
    check("rstw_data_data", data_resp_data, 0);
    tick();
    check("rstw_no_pulse", {30'b0, insn_resp_valid, data_resp_valid}, 0);
    insn_req_valid = 1; insn_addr = 32'h700;
    #1;
    check("rstw_idle_ready", {31'b0, insn_req_ready}, 1);
    tick();
    insn_req_valid = 0;
    check("rstw_next_addr", mem_addr, 32'h700);
    serve(32'h11112222);
    check("rstw_next_resp", {31'b0, insn_resp_valid}, 1);
    check("rstw_next_data", insn_resp_data, 32'h11112222);

    // Spurious response in IDLE
    tick();
    mem_resp_valid = 1; mem_resp_data = 32'h55555555;
    tick();
    mem_resp_valid = 0;
    check("spur_no_pulse", {30'b0, insn_resp_valid, data_resp_valid}, 0);
    check("spur_mem_valid", {31'b0, mem_req_valid}, 0);
    check("spur_data_hold", insn_resp_data, 32'h11112222);
    data_req_valid = 1; data_addr = 32'h800;
    #1;
    check("spur_still_idle", {31'b0, data_req_ready}, 1);
    tick();
    data_req_valid = 0;
    serve(32'h0BADF00D);
    check("spur_after_resp", data_resp_data, 32'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Shares one memory port between the core's instruction-fetch path and its load/store path. It accepts one request at a time from either requester and forwards it to memory with a valid/ready handshake. It then routes the single response back to the requester that issued it. Loads and stores have priority over fetch, and a starvation counter guarantees that fetch makes forward progress.

## Interface
- XLEN, 32, address/data width; must be a multiple of 8
- STARVE_LIMIT, 4, consecutive contended data grants before fetch wins; 0 gives fetch fixed priority
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; reset == 0 at a rising edge resets the block
- insn_req_valid  in  1  fetch request
- insn_req_ready  out  1  fetch request accepted this cycle
- insn_addr  in  XLEN  fetch address
- insn_resp_valid  out  1  one-cycle pulse: insn_resp_data valid
- insn_resp_data  out  XLEN  fetched word
- data_req_valid  in  1  load/store request
- data_req_ready  out  1  load/store accepted this cycle
- data_addr  in  XLEN  load/store address
- data_write  in  1  1 = store, 0 = load
- data_wstrb  in  XLEN/8  store byte enables
- data_wdata  in  XLEN  store data
- data_resp_valid  out  1  one-cycle pulse: load data, or store acknowledge
- data_resp_data  out  XLEN  load data; 0 for stores
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_write, mem_wstrb, mem_wdata  out  XLEN/1/XLEN/8/XLEN  registered copy of the accepted request
- mem_resp_valid  in  1  memory response; exactly one per accepted request, reads and writes alike
- mem_resp_data  in  XLEN  read data

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE:**
  - Grant selection happens only in IDLE. insn_req_ready and data_req_ready are combinational from state, the valids and starve_cnt; at most one is high.
  - Fetch is granted if insn_req_valid && (!data_req_valid || starve_cnt == STARVE_LIMIT). Otherwise data is granted if data_req_valid.
  - On a grant: latch addr, write, wstrb, wdata and owner into registers, then go to ISSUE.
  - For fetch, the registers are loaded as write=0, wstrb=0, wdata=0.
- **ISSUE:**
  - mem_req_valid = 1, driven from the registers, so memory outputs are stable until the handshake.
  - When mem_req_ready is high, go to WAIT.
- **WAIT:**
  - When mem_resp_valid is high, register the response for the owner.
  - The owner's resp_valid is high for exactly the next cycle. resp_data = mem_resp_data for a read, 0 for a write.
  - The non-owner's resp_valid stays 0. The FSM goes to IDLE.
- **Starvation counter:**
  - starve_cnt is $clog2(STARVE_LIMIT+1) bits wide.
  - Increments, saturating at STARVE_LIMIT, on a data grant while insn_req_valid is high.
  - Clears to 0 on a fetch grant.
  - Unchanged otherwise.
- mem_resp_valid in IDLE or ISSUE is a protocol violation. It is ignored and no response pulse is produced.
- resp_data holds its last value when resp_valid is low.

## Timing
- **Reset values:** state IDLE, all ready/valid outputs 0, mem_* registers 0, both resp_data 0, starve_cnt 0.
- **Latency:** accept at cycle N → mem_req_valid from N+1. Handshake at cycle H ≥ N+1 → WAIT from H+1. mem_resp_valid at cycle M ≥ H+1 → resp_valid at M+1.
- **Back-to-back:** the FSM is IDLE at M+1, so a new request can be accepted in the same cycle that the previous response pulses.
- **Peak rate:** one transaction per 3 cycles when memory answers with zero wait states.
- **Simultaneous events:**
  - Both valids high with starve_cnt < STARVE_LIMIT → data granted.
  - Both valids high with starve_cnt == STARVE_LIMIT → fetch granted.
- **Requester rules:**
  - Requesters may drop valid before acceptance; nothing is latched.
  - Request fields are sampled only in the accept cycle.
- **Reset mid-operation:**
  - The in-flight transaction is abandoned and no resp pulse is produced.
  - Memory must be reset on the same reset, so no stale response arrives later.

## Structure
- Package riscv_mem_pkg holds:
  - the state enum {IDLE, ISSUE, WAIT}
  - the owner enum {OWNER_INSN, OWNER_DATA}
  - a request struct (addr, write, wstrb, wdata) parameterised by XLEN via localparams
- One sub-module, riscv_arb_priority: grant selection plus the saturating starve_cnt. It exposes grant_insn and grant_data, and is reused for future requesters.

## Test plan
- **Single fetch:** insn_addr=0x100, memory ready immediately, mem_resp_data=0xDEADBEEF one cycle after the handshake → insn_resp_valid pulses once with 0xDEADBEEF, 3 cycles after accept; data_resp_valid stays 0.
- **Store:** data_addr=0x200, wstrb=4'b0011, wdata=0x1234 → mem_* carry exactly those values; data_resp_valid pulses with data_resp_data=0.
- **Contention:** both valids held high, STARVE_LIMIT=4 → grant order D,D,D,D,I,D,D,D,D,I; starve_cnt resets after each fetch grant.
- **Backpressure:** mem_req_ready held low for 5 cycles → mem_req_valid and mem_addr stay stable for all 5 cycles; both req_ready stay 0 until the response returns.
- **Reset in WAIT:** reset=0 for one cycle after the handshake → all outputs return to reset values; no resp pulse; the next fetch completes normally.
- **Spurious response:** mem_resp_valid=1 in IDLE → no resp pulse and no state change.
